// File: rtl/rs_encoder_serial.sv
// rs_encoder_serial: systematic RS(255,239) encoder over GF(256), one byte per cycle in and out
module gf256_mul (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  logic [7:0] x;
  always_comb begin
    y = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      y = y ^ (b[i] ? x : 8'h00);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    end
  end
endmodule

module rs_encoder_serial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop
);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2;

  function automatic logic [7:0] cmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      r = r ^ (b[i] ? x : 8'h00);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    end
    return r;
  endfunction

  // g(x) = prod (x + alpha^i), i=1..16, expanded at elaboration; g16 = 1 is implicit
  function automatic logic [15:0][7:0] gen_poly();
    logic [16:0][7:0] c;
    logic [7:0] root;
    c = '0;
    c[0] = 8'h01;
    root = 8'h01;
    for (int i = 1; i <= 16; i++) begin
      root = cmul(root, 8'h02);
      for (int j = 16; j >= 1; j--) c[j] = c[j-1] ^ cmul(root, c[j]);
      c[0] = cmul(root, c[0]);
    end
    return c[15:0];
  endfunction

  localparam logic [15:0][7:0] G = gen_poly();

  logic [1:0] state;
  logic [7:0] mcnt;
  logic [3:0] pcnt;
  logic [15:0][7:0] p, prod;
  logic [7:0] fb;
  logic advance, in_fire, par_fire;

  assign advance  = out_ready | ~out_valid;
  assign in_ready = rst_n & advance & (state != PARITY);
  assign in_fire  = in_valid & in_ready;
  assign par_fire = advance & (state == PARITY);
  assign fb       = in_data ^ p[15];

  for (genvar j = 0; j < 16; j++) begin : g_mul
    gf256_mul u_mul (.a(G[j]), .b(fb), .y(prod[j]));
  end

  // pcnt wraps 15->0 on the last parity byte, so it is already clear back in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcnt      <= '0;
      pcnt      <= '0;
      p         <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else begin
      if (in_fire) begin
        p     <= {p[14:0], 8'h00} ^ prod;
        state <= (mcnt == 8'd238) ? PARITY : DATA;
        mcnt  <= (mcnt == 8'd238) ? mcnt : mcnt + 8'd1;
      end else if (par_fire) begin
        p    <= {p[14:0], 8'h00};
        pcnt <= pcnt + 4'd1;
        if (pcnt == 4'd15) begin
          state <= IDLE;
          mcnt  <= '0;
        end
      end
      if (advance) begin
        out_valid <= in_fire | par_fire;
        out_data  <= in_fire ? in_data : par_fire ? p[15] : out_data;
        out_sop   <= in_fire & (mcnt == 8'd0);
        out_eop   <= par_fire & (pcnt == 4'd15);
      end
    end
  end
endmodule

// File: tb/tb_rs_encoder_serial.sv
// tb_rs_encoder_serial: directed and random checks of rs_encoder_serial against a table-based GF(256) model
`timescale 1ns/1ps
module tb_rs_encoder_serial;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0, in_ready;
  logic [7:0] out_data;
  logic out_valid, out_sop, out_eop;
  logic out_ready = 1'b1;

  always #5 clk = ~clk;

  rs_encoder_serial dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop)
  );

  typedef logic [7:0] msg_t [239];
  typedef logic [7:0] par_t [16];
  typedef struct {logic [7:0] d; logic sop; logic eop; time t;} rec_t;

  rec_t out_q[$];
  int tests = 0, fails = 0;
  int or_mode = 0;
  int ir_low = 0, stall_cycles = 0, stall_bad = 0;
  logic stalled = 1'b0;
  logic [9:0] held = '0;
  time t_first = 0;
  logic [7:0] exp_t [256];
  int log_t [256];
  logic [7:0] gpoly [17];

  always @(posedge clk) begin
    #1;
    out_ready = (or_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n && stalled) begin
      stall_cycles++;
      if (!(out_valid === 1'b1 && {out_data, out_sop, out_eop} === held)) stall_bad++;
    end
    stalled = rst_n && out_valid && !out_ready;
    held = {out_data, out_sop, out_eop};
    if (rst_n && out_valid && out_ready) out_q.push_back('{d: out_data, sop: out_sop, eop: out_eop, t: $time});
    if (rst_n && !in_ready) ir_low++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time %0t exceeded, expected completion", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  // long division of m(x)*x^16 by g(x); remainder occupies positions 239..254
  function automatic void encode(input msg_t m, output par_t par);
    logic [7:0] c [255];
    logic [7:0] coef;
    for (int k = 0; k < 255; k++) c[k] = (k < 239) ? m[k] : 8'h00;
    for (int k = 0; k < 239; k++) begin
      coef = c[k];
      for (int j = 0; j <= 16; j++) c[k+j] = c[k+j] ^ gmul(coef, gpoly[16-j]);
    end
    for (int t = 0; t < 16; t++) par[t] = c[239+t];
  endfunction

  function automatic int syn_nonzero(input int base);
    int n = 0;
    logic [7:0] s;
    for (int i = 1; i <= 16; i++) begin
      s = 8'h00;
      for (int k = 0; k < 255; k++) s = gmul(s, exp_t[i]) ^ out_q[base+k].d;
      if (s != 8'h00) n++;
    end
    return n;
  endfunction

  task automatic send(input msg_t m, input int n, input int gap);
    bit fired;
    int budget;
    for (int i = 0; i < n; i++) begin
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data = m[i];
      fired = 1'b0;
      budget = 0;
      while (!fired && budget < 1000) begin
        @(negedge clk);
        fired = in_ready;
        if (fired && i == 0) t_first = $time;
        @(posedge clk); #1;
        budget++;
      end
      if (!fired) begin
        tests++; fails++;
        $display("FAIL send_timeout: byte %0d not accepted, in_ready=%b, expected 1", i, in_ready);
        return;
      end
    end
  endtask

  task automatic wait_out(input int need, output bit ok);
    int b = 0;
    while (out_q.size() < need && b < 5000) begin
      @(posedge clk); #1;
      b++;
    end
    ok = out_q.size() >= need;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL out_timeout: got %0d output bytes, expected %0d", out_q.size(), need);
    end
  endtask

  task automatic check_cw(input string nm, input int base, input msg_t m);
    par_t par;
    int bad_m = 0, bad_p = 0, bad_f = 0, syn;
    encode(m, par);
    for (int k = 0; k < 239; k++) if (out_q[base+k].d !== m[k]) bad_m++;
    for (int t = 0; t < 16; t++) if (out_q[base+239+t].d !== par[t]) bad_p++;
    for (int k = 0; k < 255; k++)
      if (out_q[base+k].sop !== (k == 0) || out_q[base+k].eop !== (k == 254)) bad_f++;
    syn = syn_nonzero(base);
    tests++;
    if (bad_m != 0) begin fails++; $display("FAIL %s msg_passthrough: %0d bytes differ, expected 0", nm, bad_m); end
    tests++;
    if (bad_p != 0) begin fails++; $display("FAIL %s parity: %0d bytes differ from model, expected 0", nm, bad_p); end
    tests++;
    if (bad_f != 0) begin fails++; $display("FAIL %s sop_eop: %0d misplaced flags, expected 0", nm, bad_f); end
    tests++;
    if (syn != 0) begin fails++; $display("FAIL %s syndromes: %0d nonzero, expected 0", nm, syn); end
  endtask

  task automatic check_impulse(input string nm, input int base);
    int bad_m = 0;
    for (int k = 0; k < 238; k++) if (out_q[base+k].d !== 8'h00) bad_m++;
    tests++;
    if (bad_m != 0 || out_q[base+238].d !== 8'h01) begin
      fails++;
      $display("FAIL %s msg: %0d zero bytes wrong, last=%h, expected 0 and 01", nm, bad_m, out_q[base+238].d);
    end
    for (int t = 0; t < 16; t++) begin
      tests++;
      if (out_q[base+239+t].d !== gpoly[15-t]) begin
        fails++;
        $display("FAIL %s parity%0d: got %h, expected g%0d=%h", nm, t, out_q[base+239+t].d, 15 - t, gpoly[15-t]);
      end
    end
    tests++;
    if (out_q[base].sop !== 1'b1 || out_q[base+254].eop !== 1'b1) begin
      fails++;
      $display("FAIL %s flags: sop=%b eop=%b, expected 1 1", nm, out_q[base].sop, out_q[base+254].eop);
    end
  endtask

  function automatic msg_t impulse();
    msg_t m;
    for (int k = 0; k < 239; k++) m[k] = (k == 238) ? 8'h01 : 8'h00;
    return m;
  endfunction

  function automatic msg_t rand_msg();
    msg_t m;
    for (int k = 0; k < 239; k++) m[k] = 8'($urandom);
    return m;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready); end
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    tests++;
    if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h, expected 00", out_data); end
    tests++;
    if (out_sop !== 1'b0 || out_eop !== 1'b0) begin
      fails++; $display("FAIL reset_flags: sop=%b eop=%b, expected 0 0", out_sop, out_eop);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL in_ready_after_reset: got %b, expected 1", in_ready); end
  endtask

  task automatic test_zeros();
    msg_t m;
    int base = out_q.size(), nz = 0, nsop = 0, neop = 0;
    bit ok;
    for (int k = 0; k < 239; k++) m[k] = 8'h00;
    send(m, 239, 0);
    in_valid = 1'b0;
    wait_out(base + 255, ok);
    if (!ok) return;
    for (int k = 0; k < 255; k++) begin
      if (out_q[base+k].d !== 8'h00) nz++;
      if (out_q[base+k].sop === 1'b1) nsop++;
      if (out_q[base+k].eop === 1'b1) neop++;
    end
    tests++;
    if (nz != 0) begin fails++; $display("FAIL zeros_data: %0d nonzero bytes, expected 0", nz); end
    tests++;
    if (nsop != 1 || out_q[base].sop !== 1'b1) begin
      fails++; $display("FAIL zeros_sop: %0d sops, first=%b, expected 1 on byte 1", nsop, out_q[base].sop);
    end
    tests++;
    if (neop != 1 || out_q[base+254].eop !== 1'b1) begin
      fails++; $display("FAIL zeros_eop: %0d eops, last=%b, expected 1 on byte 255", neop, out_q[base+254].eop);
    end
    tests++;
    if ((out_q[base+254].t - t_first) / 10 + 1 != 256) begin
      fails++; $display("FAIL zeros_latency: %0d cycles, expected 256", (out_q[base+254].t - t_first) / 10 + 1);
    end
  endtask

  task automatic test_impulse();
    int base = out_q.size();
    bit ok;
    send(impulse(), 239, 0);
    in_valid = 1'b0;
    wait_out(base + 255, ok);
    if (ok) check_impulse("impulse", base);
  endtask

  task automatic test_random();
    msg_t m;
    int base;
    bit ok;
    for (int c = 0; c < 100; c++) begin
      m = rand_msg();
      base = out_q.size();
      send(m, 239, 0);
      in_valid = 1'b0;
      wait_out(base + 255, ok);
      if (!ok) return;
      check_cw($sformatf("rand%0d", c), base, m);
    end
  endtask

  task automatic test_stall();
    msg_t ms [4];
    rec_t rf [$];
    int base, bad = 0, sc0, sb0;
    bit ok;
    for (int c = 0; c < 4; c++) ms[c] = rand_msg();
    base = out_q.size();
    for (int c = 0; c < 4; c++) send(ms[c], 239, 0);
    in_valid = 1'b0;
    wait_out(base + 1020, ok);
    if (!ok) return;
    for (int k = 0; k < 1020; k++) rf.push_back(out_q[base+k]);
    sc0 = stall_cycles;
    sb0 = stall_bad;
    or_mode = 1;
    base = out_q.size();
    for (int c = 0; c < 4; c++) send(ms[c], 239, 30);
    in_valid = 1'b0;
    wait_out(base + 1020, ok);
    or_mode = 0;
    repeat (20) @(posedge clk);
    #1;
    if (ok) begin
      for (int k = 0; k < 1020; k++)
        if (out_q[base+k].d !== rf[k].d || out_q[base+k].sop !== rf[k].sop || out_q[base+k].eop !== rf[k].eop) bad++;
      tests++;
      if (bad != 0) begin fails++; $display("FAIL stall_sequence: %0d bytes differ from unstalled run, expected 0", bad); end
      tests++;
      if (out_q.size() != base + 1020) begin
        fails++; $display("FAIL stall_count: %0d output bytes, expected 1020", out_q.size() - base);
      end
      for (int c = 0; c < 4; c++) check_cw($sformatf("stall%0d", c), base + 255 * c, ms[c]);
    end
    tests++;
    if (stall_bad - sb0 != 0) begin
      fails++; $display("FAIL stall_hold: %0d stalled cycles changed output, expected 0", stall_bad - sb0);
    end
    tests++;
    if (stall_cycles - sc0 == 0) begin fails++; $display("FAIL stall_exercised: 0 stalled cycles, expected >0"); end
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    send(rand_msg(), 120, 0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL async_reset: out_valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = out_q.size();
    send(impulse(), 239, 0);
    in_valid = 1'b0;
    wait_out(base + 255, ok);
    if (ok) check_impulse("after_reset", base);
  endtask

  task automatic test_back_to_back();
    msg_t ms [3];
    int base = out_q.size(), ir0 = ir_low;
    bit ok;
    for (int c = 0; c < 3; c++) ms[c] = rand_msg();
    for (int c = 0; c < 3; c++) send(ms[c], 239, 0);
    in_valid = 1'b0;
    wait_out(base + 765, ok);
    if (!ok) return;
    tests++;
    if (ir_low - ir0 != 48) begin fails++; $display("FAIL b2b_in_ready_low: %0d cycles, expected 48", ir_low - ir0); end
    for (int c = 1; c < 3; c++) begin
      tests++;
      if (out_q[base+255*c].sop !== 1'b1 || out_q[base+255*c].t - out_q[base+255*c-1].t != 10) begin
        fails++;
        $display("FAIL b2b_sop_after_eop%0d: sop=%b gap=%0t, expected 1 and 10", c,
                 out_q[base+255*c].sop, out_q[base+255*c].t - out_q[base+255*c-1].t);
      end
    end
    for (int c = 0; c < 3; c++) check_cw($sformatf("b2b%0d", c), base + 255 * c, ms[c]);
  endtask

  initial begin
    int x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = 8'(x);
      log_t[x] = i;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11d;
    end
    exp_t[255] = exp_t[0];
    log_t[0] = 0;
    for (int j = 0; j < 17; j++) gpoly[j] = 8'h00;
    gpoly[0] = 8'h01;
    for (int i = 1; i <= 16; i++) begin
      for (int j = 16; j >= 1; j--) gpoly[j] = gpoly[j-1] ^ gmul(gpoly[j], exp_t[i]);
      gpoly[0] = gmul(gpoly[0], exp_t[i]);
    end
    test_reset();
    test_zeros();
    test_impulse();
    test_random();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
